// File: rtl/mbw_pkg.sv
// Shared constants and enums for the SPI-slave memory wrapper.
package mbw_pkg;
  localparam int MEM_DEPTH  = 256;
  localparam int ADDR_SIZE  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SHIFT_IN,
    SHIFT_OUT,
    DONE
  } state_e;
endpackage

// File: rtl/mbw_spram.sv
// Synchronous single-port RAM, read-first, registered output, contents not reset.
module mbw_spram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;
endmodule

// File: rtl/memory_block_wrapper.sv
// SPI-slave front end for a 256x8 RAM; 2-bit command + 8-bit payload per frame.
// Optional address auto-increment enabled by MBW_ADDR_AUTO_INC_EN.
module memory_block_wrapper
  import mbw_pkg::*;
#(
  parameter int MEM_DEPTH = mbw_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = mbw_pkg::ADDR_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);
  state_e                 state_q, state_d;
  cmd_e                   cmd_q, cmd_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             sh_q, sh_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   miso_q, miso_d;
  logic                   fetch_q, fetch_d;

  logic                   ram_we;
  logic [ADDR_SIZE-1:0]   ram_addr;
  logic [7:0]             ram_dout;
  logic [7:0]             payload;

  assign payload = {sh_q[6:0], MOSI};

  mbw_spram #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE), .DW(8)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (payload),
    .dout (ram_dout)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    miso_d    = 1'b0;
    fetch_d   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = wr_addr_q;

    // RAM output is registered, so a fetch issued on one edge lands here on the next.
    if (fetch_q) rd_data_d = ram_dout;

    if (SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_d   = cmd_e'({MOSI, 1'b0});
          cnt_d   = 4'd1;
          state_d = CMD;
        end
        CMD: begin
          cmd_d = cmd_e'({cmd_q[1], MOSI});
          cnt_d = 4'd2;
          if ({cmd_q[1], MOSI} == RD_DATA) begin
            state_d = SHIFT_OUT;
            miso_d  = rd_data_q[7];
          end else begin
            state_d = SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          sh_d  = payload;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = DONE;
            case (cmd_q)
              WR_ADDR: wr_addr_d = ADDR_SIZE'(payload);
              WR_DATA: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr_q;
`ifdef MBW_ADDR_AUTO_INC_EN
                wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`endif
              end
              RD_ADDR: begin
                rd_addr_d = ADDR_SIZE'(payload);
                ram_addr  = ADDR_SIZE'(payload);
                fetch_d   = 1'b1;
              end
              default: ;
            endcase
          end
        end
        SHIFT_OUT: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = DONE;
`ifdef MBW_ADDR_AUTO_INC_EN
            rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
            ram_addr  = rd_addr_q + ADDR_SIZE'(1);
            fetch_d   = 1'b1;
`endif
          end else begin
            // Edge k (3..9) presents rd_data[9-k]; cnt_q holds k-1 here.
            miso_d = rd_data_q[3'(4'd8 - cnt_q)];
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= WR_ADDR;
      cnt_q     <= '0;
      sh_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      miso_q    <= 1'b0;
      fetch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      miso_q    <= miso_d;
      fetch_q   <= fetch_d;
    end
  end

  assign MISO = miso_q;
endmodule

// File: tb/tb_memory_block_wrapper.sv
// Directed bench for memory_block_wrapper; auto-increment cases run when MBW_ADDR_AUTO_INC_EN is defined.
module tb_memory_block_wrapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic MOSI = 1'b0;
  logic SS_n = 1'b1;
  logic MISO;
  logic last_miso;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_block_wrapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MOSI  (MOSI),
    .SS_n  (SS_n),
    .MISO  (MISO)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask

  // Drives nbits rising edges with SS_n low; MISO captured on falling edges after edges 2..9.
  task automatic frame(input logic [1:0] cmd, input logic [7:0] pl, input int nbits,
                       output logic [7:0] rx);
    logic [9:0] bits;
    bits = {cmd, pl};
    rx   = '0;
    for (int k = 1; k <= nbits; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 10) rx[10-k] = MISO;
      SS_n = 1'b0;
      MOSI = (k <= 10) ? bits[10-k] : 1'b1;
    end
    @(negedge clk);
    last_miso = MISO;
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    frame(2'b00, a, 10, rx);
    frame(2'b01, d, 10, rx);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] rx;
    frame(2'b10, a, 10, rx);
    frame(2'b11, 8'h00, 10, d);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] exp;

    rst_n = 1'b0;
    SS_n  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_miso", {7'b0, MISO}, 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_miso", {7'b0, MISO}, 8'h00);
    end

    frame(2'b11, 8'h00, 10, rx);
    chk("rd_before_addr", rx, 8'h00);
    chk("miso_edge10", {7'b0, last_miso}, 8'h00);

`ifndef MBW_ADDR_AUTO_INC_EN
    wr(8'h05, 8'h77);
    chk("wr_miso_idle", {7'b0, last_miso}, 8'h00);
    frame(2'b11, 8'h00, 10, rx);
    chk("rd_old_rd_data", rx, 8'h00);
`endif

    wr(8'h64, 8'h0B);
    rd(8'h64, rx);
    exp = 8'h0B;
    for (int i = 7; i >= 0; i--) chk("single_bit", {7'b0, rx[i]}, {7'b0, exp[i]});
    chk("single_byte", rx, 8'h0B);
    chk("rd_miso_tail", {7'b0, last_miso}, 8'h00);

    wr(8'h10, 8'h5A);
    frame(2'b00, 8'h10, 10, rx);
    frame(2'b01, 8'hAA, 6, rx);
    rd(8'h10, rx);
    chk("abort_wr", rx, 8'h5A);

    frame(2'b10, 8'h33, 4, rx);
    frame(2'b11, 8'h00, 10, rx);
`ifndef MBW_ADDR_AUTO_INC_EN
    chk("abort_rd_addr", rx, 8'h5A);
`endif

    frame(2'b00, 8'h20, 10, rx);
    frame(2'b01, 8'h3C, 13, rx);
    rd(8'h20, rx);
    chk("extra_bits", rx, 8'h3C);

    for (int i = 0; i < 100; i++) wr(8'(100 + i), 8'(11 * ((i % 23) + 1)));
    for (int i = 0; i < 100; i++) begin
      rd(8'(100 + i), rx);
      chk("fill", rx, 8'(11 * ((i % 23) + 1)));
    end

`ifdef MBW_ADDR_AUTO_INC_EN
    frame(2'b00, 8'hFF, 10, rx);
    frame(2'b01, 8'h11, 10, rx);
    frame(2'b01, 8'h22, 10, rx);
    frame(2'b10, 8'hFF, 10, rx);
    frame(2'b11, 8'h00, 10, rx);
    chk("ainc_rd_ff", rx, 8'h11);
    frame(2'b11, 8'h00, 10, rx);
    chk("ainc_rd_00", rx, 8'h22);
    rd(8'hFF, rx);
    chk("ainc_mem_ff", rx, 8'h11);
    rd(8'h00, rx);
    chk("ainc_mem_00", rx, 8'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memory_block_wrapper.md
# memory_block_wrapper

SPI-slave-accessed 256 x 8 single-port RAM. Sits at the chip boundary and is the only path by which an external SPI master reads and writes on-chip storage. Each transaction is a 2-bit command plus 8 payload bits, MSB first, framed by an active-low select. The clock is the SPI serial clock itself.

## Interface
- MEM_DEPTH, 256, number of memory words.
- ADDR_SIZE, 8, address width in bits; MEM_DEPTH = 2**ADDR_SIZE.
- clk  in  1  single clock; all inputs sampled and all state updated on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- MOSI  in  1  serial data from master, sampled on rising clk.
- MISO  out  1  serial data to master, registered, changes only on rising clk.
- SS_n  in  1  active-low frame select.

## Operation
- **Frame start.** A frame is the run of rising edges with SS_n low.
  - Bit 1 = CMD[1], bit 2 = CMD[0], bits 3..10 = payload[7:0], MSB first.
- **Commands**, all executed at the 10th edge unless noted:
  - 00 write-address: payload latched into wr_addr.
  - 01 write-data: mem[wr_addr] <= payload.
  - 10 read-address: payload latched into rd_addr; rd_data <= mem[rd_addr] on the following edge.
  - 11 read-data: MOSI after bit 2 is ignored; rd_data is shifted out on MISO, MSB first.
- **States:**
  - IDLE: SS_n high.
  - CMD: bits 1–2.
  - SHIFT_IN: commands 00/01/10.
  - SHIFT_OUT: command 11.
  - DONE: after 10 bits, waiting for SS_n high.
  - SS_n high in any state returns to IDLE.
- **Aborts and extra bits.**
  - SS_n rising before the 10th edge aborts the frame: no register or memory change.
  - Edges beyond the 10th with SS_n still low are ignored.
- **Separate pointers.** wr_addr and rd_addr are independent registers.
- **Reset.**
  - Values: MISO=0, state=IDLE, wr_addr=0, rd_addr=0, rd_data=0.
  - Memory contents are not reset.
  - A reset mid-frame aborts the frame.
- **Read before address.** Read-data with no prior read-address after reset returns 0x00.

## Timing
- **Write.** The write is visible in memory at the 10th edge of the 01 frame.
- **Read-address to read-data.** rd_data is valid one edge after the 10th edge of the 10 frame.
  - The mandatory SS_n-high edge guarantees this precedes any read-data frame.
- **MISO in a read-data frame.**
  - Edge 2 (CMD=11 complete): MISO <= rd_data[7].
  - Edges 3..9: MISO <= rd_data[6..0].
  - Edge 10: MISO <= 0.
  - The master samples on the falling edge following edges 2..9.
- **MISO at other times.** MISO = 0 whenever not in SHIFT_OUT.
- **Back-to-back frames.** A minimum of one rising edge with SS_n high between frames is required.
- **Address arithmetic.** Addresses are ADDR_SIZE bits, unsigned; increments wrap modulo MEM_DEPTH.

## Configuration
- MBW_ADDR_AUTO_INC_EN defined:
  - After each completed 01 frame, wr_addr <= wr_addr+1.
  - After each completed 11 frame, rd_addr <= rd_addr+1 and rd_data is refetched from the new rd_addr on the next edge.
  - 0xFF wraps to 0x00.
- Undefined: addresses change only via 00/10 frames.
- Aborted frames never increment.

## Structure
- Package mbw_pkg holds:
  - MEM_DEPTH/ADDR_SIZE defaults;
  - command enum (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11);
  - state enum (IDLE, CMD, SHIFT_IN, SHIFT_OUT, DONE);
  - FRAME_BITS=10.
- One sub-module, mbw_spram: synchronous single-port RAM (we, addr, din, registered dout), with no reset on contents.
- SPI FSM, shift register, bit counter and address registers live in the top.

## Test plan
- **Reset.** Hold rst_n low 5 cycles with SS_n=1 -> MISO=0 throughout, including after release.
- **Single write/read.** Write-address 0x64, write-data 0x0B, read-address 0x64, read-data -> MISO bits 0,0,0,0,1,0,1,1 on the falling edges after edges 2..9.
- **Sequential fill.** Addresses 100..199 with data 11,22,…,253, then wrapping back to 11; read all back -> every word matches.
- **Abort.** Write-address 0x10, then a write-data frame of 0xAA with SS_n raised after bit 6 -> reading 0x10 returns its prior value.
- **Read before address.** Read-data immediately after reset -> 0x00. Write to 0x05 with no read-address -> read-data still returns the old rd_data.
- **Auto-increment.** With MBW_ADDR_AUTO_INC_EN:
  - write-address 0xFF, write-data 0x11, write-data 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22;
  - read-address 0xFF, two read-data frames -> 0x11 then 0x22.
